// File: rtl/mod47_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod47_pkg
// Description : Shared constants and FSM state type for the mod-47 residue
//               accumulator slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mod47_pkg;

  localparam int MOD_P = 47;
  localparam int RES_W = 6;

  // ACC: collecting partial residues; OUT: presenting the frame result.
  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

endpackage : mod47_pkg
`default_nettype wire

// File: rtl/mod47_residue_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : mod47_residue_accum_if
// Description : Input-beat and output-result handshake bundle of the mod-47
//               residue accumulator. The master side feeds partial residues
//               and consumes results; the slave side is the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod47_residue_accum_if;
  import mod47_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface : mod47_residue_accum_if
`default_nettype wire

// File: rtl/mod47_add.sv
`default_nettype none
// ============================================================================
// Module      : mod47_add
// Description : Combinational modular adder, sum = (a + b) mod 47, for
//               operands already in 0..46. A 7-bit sum (max 92) needs at
//               most one subtraction of 47.
// Revision    : 1.0 - initial release
// ============================================================================
module mod47_add
  import mod47_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] sum
);

  logic [RES_W:0]   w_raw;
  logic [RES_W-1:0] w_sub;

  assign w_raw = {1'b0, a} + {1'b0, b};
  // The reduced value always fits in 6 bits, so the subtraction can be done
  // modulo 64 on the low bits without losing anything.
  assign w_sub = w_raw[RES_W-1:0] - RES_W'(MOD_P);

  // Conditional subtraction selects the reduced value once the sum reaches 47.
  always_comb begin
    sum = w_raw[RES_W-1:0];
    if (w_raw >= (RES_W+1)'(MOD_P)) begin
      sum = w_sub;
    end
  end

endmodule : mod47_add
`default_nettype wire

// File: rtl/mod47_residue_accum.sv
`default_nettype none
// ============================================================================
// Module      : mod47_residue_accum
// Description : Sums NUM_CHUNKS 6-bit partial residues per frame modulo 47
//               and presents the frame residue on a valid/ready output.
//               Optional build macro MOD47_ACC_RANGE_CHECK_EN adds a sticky
//               err output and pre-reduces inputs of 47..63.
// Revision    : 1.0 - initial release
// ============================================================================
module mod47_residue_accum
  import mod47_pkg::*;
#(
  parameter int NUM_CHUNKS = 8
)(
  input  logic                  clk,
  input  logic                  rst_n,
  mod47_residue_accum_if.slave  bus
`ifdef MOD47_ACC_RANGE_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int                CNT_W       = $clog2(NUM_CHUNKS);
  localparam logic [CNT_W-1:0]  c_last_beat = CNT_W'(NUM_CHUNKS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [RES_W-1:0] r_acc;
  logic [RES_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_count;
  logic [RES_W-1:0] w_in_term;
  logic [RES_W-1:0] w_acc_next;
  logic             w_in_fire;
  logic             w_last_beat;

  // Handshakes decoded from state directly so the outputs never feed back.
  assign w_in_fire   = bus.in_valid && (r_state == ST_ACC);
  assign w_last_beat = (r_count == c_last_beat);

`ifdef MOD47_ACC_RANGE_CHECK_EN
  logic r_err;
  logic w_in_oor;

  assign w_in_oor  = (bus.in_data >= RES_W'(MOD_P));
  assign w_in_term = w_in_oor ? (bus.in_data - RES_W'(MOD_P)) : bus.in_data;
  assign err       = r_err;

  // Sticky flag: any accepted out-of-range beat latches it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_in_fire && w_in_oor) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_in_term = bus.in_data;
`endif

  mod47_add u_add (
    .a   (r_acc),
    .b   (w_in_term),
    .sum (w_acc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; out_ready only matters in OUT.
  always_comb begin
    w_state_next  = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_ACC: begin
        bus.in_ready = 1'b1;
        if (w_in_fire && w_last_beat) begin
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = ST_ACC;
        end
      end
      default: begin
        w_state_next = ST_ACC;
      end
    endcase
  end

  // Accumulator, beat counter and result register; the last beat of a frame
  // captures the result and clears acc so the next frame starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_out_data <= '0;
    end else if (w_in_fire) begin
      if (w_last_beat) begin
        r_out_data <= w_acc_next;
        r_acc      <= '0;
        r_count    <= '0;
      end else begin
        r_acc      <= w_acc_next;
        r_count    <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.out_data = r_out_data;

endmodule : mod47_residue_accum
`default_nettype wire

// File: tb/tb_mod47_residue_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod47_residue_accum
// Description : Self-checking bench for mod47_residue_accum: directed frames
//               with literal expectations plus randomized traffic compared
//               every cycle against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod47_residue_accum;
  import mod47_pkg::*;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_beats[$];
  bit m_pending = 1'b0;
  int m_data    = 0;
  bit m_err     = 1'b0;
  int m_frames  = 0;

  always #5 clk = ~clk;

  mod47_residue_accum_if bus();

`ifdef MOD47_ACC_RANGE_CHECK_EN
  logic err;
`endif

  mod47_residue_accum #(.NUM_CHUNKS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MOD47_ACC_RANGE_CHECK_EN
    ,
    .err   (err)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame residue from the spec's rules: plain sum of (reduced) beats mod 47.
  function automatic int frame_residue(input int q[$]);
    int s = 0;
    foreach (q[i]) begin
`ifdef MOD47_ACC_RANGE_CHECK_EN
      s += (q[i] >= 47) ? q[i] - 47 : q[i];
`else
      s += q[i];
`endif
    end
    return s % 47;
  endfunction

  // Compare process: on each falling edge, check DUT against the model, then
  // advance the model by what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_beats.delete();
      m_pending = 1'b0;
      m_data    = 0;
      m_err     = 1'b0;
      chk("rst_out_data", int'(bus.out_data), 0);
    end
    chk("in_ready", int'(bus.in_ready), int'(!m_pending));
    chk("out_valid", int'(bus.out_valid), int'(m_pending));
    if (m_pending) chk("out_data", int'(bus.out_data), m_data);
`ifdef MOD47_ACC_RANGE_CHECK_EN
    chk("err", int'(err), int'(m_err));
`endif
    if (rst_n) begin
      if (!m_pending) begin
        if (bus.in_valid) begin
          m_beats.push_back(int'(bus.in_data));
          if (bus.in_data >= 6'd47) m_err = 1'b1;
          if (m_beats.size() == N) begin
            m_data    = frame_residue(m_beats);
            m_pending = 1'b1;
            m_beats.delete();
          end
        end
      end else if (bus.out_ready) begin
        m_pending = 1'b0;
        m_frames++;
      end
    end
  end

  // Back-to-back frame, literal result check, optional hold with in_valid
  // pulses, then accept the result. Entered and left at posedge+1.
  task automatic run_frame(input int v[N], input int hold, input int exp, input string name);
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 6'(v[i]);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_data"}, int'(bus.out_data), exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.in_valid = h[0];
      bus.in_data  = 6'd9;
      @(negedge clk);
      chk({name, "_hold_valid"}, int'(bus.out_valid), 1);
      chk({name, "_hold_data"}, int'(bus.out_data), exp);
      chk({name, "_hold_rdy"}, int'(bus.in_ready), 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int fr[N];
    int cyc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Eight beats of 46 with a 5-cycle output stall.
    fr = '{46, 46, 46, 46, 46, 46, 46, 46};
    run_frame(fr, 5, 39, "f46");
    fr = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame(fr, 0, 36, "f1to8");
    fr = '{46, 1, 0, 0, 0, 0, 0, 0};
    run_frame(fr, 0, 0, "wrap");

    // out_ready held high in ACC must not matter.
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset mid-frame after 3 beats of 10 discards them.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 6'd10;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fr = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(fr, 0, 0, "post_rst");

`ifdef MOD47_ACC_RANGE_CHECK_EN
    fr = '{50, 0, 0, 0, 0, 0, 0, 0};
    run_frame(fr, 0, 3, "range");
    chk("range_err", int'(err), 1);
    fr = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame(fr, 0, 36, "clean");
    chk("clean_err", int'(err), 1);
`endif

    // Randomized traffic for 1000 frames.
    m_frames = 0;
    cyc = 0;
    while (m_frames < 1000 && cyc < 60000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
`ifdef MOD47_ACC_RANGE_CHECK_EN
      bus.in_data   = 6'($urandom_range(0, 63));
`else
      bus.in_data   = 6'($urandom_range(0, 46));
`endif
      bus.out_ready = ($urandom_range(0, 1) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("random_frames_done", int'(m_frames >= 1000), 1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mod47_residue_accum
`default_nettype wire
